// File: rtl/accel_exec_pkg.sv
// Shared decode constants, FSM encoding and helpers for the accelerator execute stage.
package accel_exec_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_CNN0   = 7'b1111110;
  localparam logic [6:0] OPC_CNN1   = 7'b1111111;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CNN_REQ  = 2'd1,
    CNN_WAIT = 2'd2
  } state_t;

  function automatic logic is_cnn_op(input logic [6:0] opc);
    return (opc == OPC_CNN0) || (opc == OPC_CNN1);
  endfunction

endpackage

// File: rtl/accel_execute_stage_exec_alu.sv
// Combinational RV32I-style ALU; result width follows XLEN.
module exec_alu
  import accel_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] o_result
);

  localparam int SHW = $clog2(XLEN);

  logic [6:0]             w_opc;
  logic [2:0]             w_f3;
  logic                   w_alt;
  logic [XLEN-1:0]        w_b;
  logic signed [XLEN-1:0] w_a_s;
  logic signed [XLEN-1:0] w_b_s;
  logic [SHW-1:0]         w_shamt;
  logic [XLEN-1:0]        w_op_res;

  assign w_opc   = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_alt   = i_instr[30];
  assign w_b     = (w_opc == OPC_OP) ? i_rs2 : i_imm;
  assign w_a_s   = i_rs1;
  assign w_b_s   = w_b;
  assign w_shamt = w_b[SHW-1:0];

  // SUB exists only for register-register ops; instr[30] in ADDI is an immediate bit.
  always_comb begin
    w_op_res = '0;
    case (w_f3)
      F3_ADD:  w_op_res = (w_opc == OPC_OP && w_alt) ? (i_rs1 - w_b) : (i_rs1 + w_b);
      F3_SLL:  w_op_res = i_rs1 << w_shamt;
      F3_SLT:  w_op_res = XLEN'(w_a_s < w_b_s);
      F3_SLTU: w_op_res = XLEN'(i_rs1 < w_b);
      F3_XOR:  w_op_res = i_rs1 ^ w_b;
      F3_SR: begin
        if (w_alt) w_op_res = w_a_s >>> w_shamt;
        else       w_op_res = i_rs1 >> w_shamt;
      end
      F3_OR:   w_op_res = i_rs1 | w_b;
      F3_AND:  w_op_res = i_rs1 & w_b;
      default: w_op_res = '0;
    endcase
  end

  always_comb begin
    o_result = '0;
    case (w_opc)
      OPC_OP, OPC_OP_IMM:           o_result = w_op_res;
      OPC_LOAD, OPC_STORE, OPC_JALR: o_result = i_rs1 + i_imm;
      OPC_LUI, OPC_AUIPC:           o_result = i_imm;
      default:                      o_result = '0;
    endcase
  end

endmodule

// File: rtl/accel_execute_stage.sv
// Execute stage: single-cycle ALU ops and multi-cycle CNN accelerator ops with timeout.
module accel_execute_stage
  import accel_exec_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int IMG_IDX_W   = 5,
  parameter int PRED_W      = 4,
  parameter int CNN_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [XLEN-1:0]      rs1_val,
  input  logic [XLEN-1:0]      rs2_val,
  input  logic [XLEN-1:0]      imm,
  input  logic [4:0]           rd,
  input  logic                 rd_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_val,
  output logic [XLEN-1:0]      out_rs2,
  output logic [4:0]           out_rd,
  output logic                 out_we,
  output logic                 out_is_cnn,
  output logic                 out_err,
  output logic                 cnn_start,
  output logic [IMG_IDX_W-1:0] cnn_img_index,
  input  logic [PRED_W-1:0]    cnn_pred,
  input  logic                 cnn_done
);

  localparam logic [CNT_W:0] TMO = (CNT_W+1)'(CNN_TIMEOUT);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] w_alu_res;
  logic            w_accept;
  logic            w_is_cnn;
  logic            w_done;
  logic            w_timeout;
  logic [4:0]      r_cnn_rd;
  logic            r_cnn_we;
  logic [XLEN-1:0] r_cnn_rs2;

  exec_alu #(.XLEN(XLEN)) u_alu (
    .i_instr  (instr),
    .i_rs1    (rs1_val),
    .i_rs2    (rs2_val),
    .i_imm    (imm),
    .o_result (w_alu_res)
  );

  assign in_ready  = !reset && (r_state == IDLE) && (!out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_is_cnn  = is_cnn_op(instr[6:0]);
  assign w_done    = (r_state == CNN_WAIT) && cnn_done;
  // Fires on the wait cycle that would bring the counter to CNN_TIMEOUT; done takes priority.
  assign w_timeout = (r_state == CNN_WAIT) && !cnn_done && (({1'b0, r_cnt} + 1'b1) >= TMO);
  assign cnn_start = (r_state == CNN_REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_accept && w_is_cnn) w_state_nxt = CNN_REQ;
      CNN_REQ:  w_state_nxt = CNN_WAIT;
      CNN_WAIT: if (w_done || w_timeout) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  r_cnt <= '0;
    else if (r_state == CNN_REQ)                r_cnt <= '0;
    else if (r_state == CNN_WAIT && !cnn_done)  r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_is_cnn) begin
      r_cnn_rd  <= rd;
      r_cnn_we  <= rd_we;
      r_cnn_rs2 <= rs2_val;
    end
  end

  // Result register: a new result only loads when the slot is empty or being drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_val       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_we        <= 1'b0;
      out_is_cnn    <= 1'b0;
      out_err       <= 1'b0;
      cnn_img_index <= '0;
    end else begin
      if (w_accept && !w_is_cnn) begin
        out_valid  <= 1'b1;
        out_val    <= w_alu_res;
        out_rs2    <= rs2_val;
        out_rd     <= rd;
        out_we     <= rd_we;
        out_is_cnn <= 1'b0;
        out_err    <= 1'b0;
      end else if (w_done || w_timeout) begin
        out_valid  <= 1'b1;
        out_val    <= w_done ? XLEN'(cnn_pred) : '0;
        out_rs2    <= r_cnn_rs2;
        out_rd     <= r_cnn_rd;
        out_we     <= r_cnn_we;
        out_is_cnn <= 1'b1;
        out_err    <= w_timeout;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
      if (w_accept && w_is_cnn) cnn_img_index <= rs1_val[IMG_IDX_W-1:0];
    end
  end

endmodule
